clock_divider_multi: RTL
========================

Name: clock_divider_multi

Overview:
- Parametrised, runtime-programmable successor to the fixed 50 MHz → 10 kHz divider.
- Provides N_CH independent divided clocks from one input clock.
- Each channel has a 50%-duty clock output and a single-cycle tick strobe.
- Divisors can be rewritten at runtime; a new divisor takes effect glitch-free at the channel's next half-period boundary.
- Sits between the board oscillator and the timing consumers: display scan, debounce, UART baud.

Parameters:
- N_CH, 2, number of independent divider channels (1..8).
- DIV_W, 26, width of the half-period count register.
- DEFAULT_HALF, 2499, reset half-period terminal count; 2499 gives 10 kHz from 50 MHz.

Ports:
- clk_in  input  1  input clock, 50 MHz nominal; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  N_CH  per-channel run enable.
- sync_clr  input  1  synchronous phase realignment of all channels.
- wr_en  input  1  divisor write strobe, single cycle.
- wr_ch  input  3  target channel index for a write.
- wr_half  input  DIV_W  new half-period terminal count.
- clk_out  output  N_CH  divided clocks, registered.
- tick  output  N_CH  one-clk_in-cycle pulse at every clk_out toggle, registered.
- pending  output  N_CH  high while a written divisor waits to be applied.

Behaviour:
- Reset (reset=0, asynchronous), all channels:
  - cnt=0, half_q=DEFAULT_HALF, pend_q=0, pend_valid=0.
  - clk_out=0, tick=0, pending=0.
- Output period = 2*(half_q+1) clk_in cycles; duty is exactly 50%.
- half_q=0 is legal: clk_out toggles every cycle, i.e. clk_in/2.
- Per channel, in each cycle with enable=1 and sync_clr=0:
  - If cnt==half_q (terminal): cnt←0, clk_out←~clk_out, tick←1, and half_q←next_half (see Writes).
  - Otherwise: cnt←cnt+1, tick←0.
- tick is high in the same cycle clk_out shows its new value.
- Latency: the first toggle occurs half_q+1 cycles after enable rises from a cleared state.
- Writes:
  - wr_en=1 with wr_ch<N_CH: pend_q[wr_ch]←wr_half, pend_valid←1.
  - wr_ch≥N_CH: write ignored, no state change.
  - next_half = wr_half if a write to this channel occurs in the same cycle, else pend_q when pend_valid=1, else half_q.
  - On terminal: half_q←next_half, pend_valid←0.
  - A second write before terminal overwrites pend_q; last write wins.
  - pending output = pend_valid.
- enable=0:
  - Next cycle: cnt←0, clk_out←0, tick←0.
  - If pend_valid=1, half_q←pend_q and pend_valid←0 immediately.
  - A write while disabled goes straight to half_q; pending stays 0.
  - On re-enable, the channel restarts from phase 0.
- sync_clr=1 (overrides enable and terminal):
  - All channels: cnt←0, clk_out←0, tick←0.
  - Pending divisors are retained; writes that cycle are still captured into pend_q.
- Counter arithmetic is DIV_W wide. cnt never exceeds half_q, so no wrap occurs.
- If half_q shrinks below cnt at terminal, this is impossible by construction: the change applies only when cnt resets to 0.
- Reset asserted mid-operation returns every channel to reset state on the same edge, with no partial update.

Test Plan:
- Reset release, enable=2'b01, defaults:
  - ch0 clk_out first rises 2500 cycles after enable.
  - Period is 5000 cycles; tick pulses every 2500 cycles, 1 cycle wide.
  - ch1 holds 0.
- Runtime write wr_ch=0, wr_half=4 mid-half-period:
  - pending[0]=1 until the next terminal count.
  - The current half-period completes at 2500; subsequent half-periods are 5 cycles.
  - pending[0] drops on that terminal.
- Write coinciding with terminal count (wr_half=1):
  - The new value is applied at that same terminal.
  - The next half-period is 2 cycles; pending stays 0.
- half_q=0 on ch1, enabled: clk_out[1] toggles every cycle (25 MHz) and tick[1] is constantly 1.
- Two channels running (half 3 and 7), sync_clr pulsed for 1 cycle:
  - Both clk_out go 0 next cycle.
  - Both restart aligned: ch0 toggles 4 cycles later, ch1 toggles 8 cycles later.
- Edge cases:
  - wr_ch=5 with N_CH=2 → no change.
  - enable dropped with pend_valid=1 → half_q updated, pending=0, clk_out=0.
  - reset pulsed mid-count → all outputs 0 immediately (asynchronous), half_q=2499.

Source files
------------

// File: rtl/clock_divider_multi.sv
// Multi-channel runtime-programmable clock divider with 50% duty outputs.
// Ports: clk_in, reset (async low), enable[N_CH], sync_clr, wr_en/wr_ch/wr_half
//        divisor write, clk_out[N_CH], tick[N_CH], pending[N_CH].
module clock_divider_multi #(
  parameter int N_CH         = 2,
  parameter int DIV_W        = 26,
  parameter int DEFAULT_HALF = 2499
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [N_CH-1:0]  enable,
  input  logic             sync_clr,
  input  logic             wr_en,
  input  logic [2:0]       wr_ch,
  input  logic [DIV_W-1:0] wr_half,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  pending
);

  localparam logic [DIV_W-1:0] RST_HALF = DIV_W'(DEFAULT_HALF);

  logic [DIV_W-1:0] cnt_q  [N_CH];
  logic [DIV_W-1:0] cnt_d  [N_CH];
  logic [DIV_W-1:0] half_q [N_CH];
  logic [DIV_W-1:0] half_d [N_CH];
  logic [DIV_W-1:0] pend_q [N_CH];
  logic [DIV_W-1:0] pend_d [N_CH];
  logic [N_CH-1:0]  pv_q, pv_d;
  logic [N_CH-1:0]  clk_q, clk_d;
  logic [N_CH-1:0]  tick_q, tick_d;

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      logic             hit;
      logic [DIV_W-1:0] nxt;
      hit = wr_en && (wr_ch == 3'(c));
      nxt = hit ? wr_half : (pv_q[c] ? pend_q[c] : half_q[c]);
      cnt_d[c]  = cnt_q[c];
      half_d[c] = half_q[c];
      pend_d[c] = pend_q[c];
      pv_d[c]   = pv_q[c];
      clk_d[c]  = clk_q[c];
      tick_d[c] = 1'b0;
      if (sync_clr) begin
        // Phase realign only; divisor bookkeeping continues.
        cnt_d[c] = '0;
        clk_d[c] = 1'b0;
        if (hit) begin
          pend_d[c] = wr_half;
          pv_d[c]   = 1'b1;
        end
      end else if (!enable[c]) begin
        // Idle channel: divisor changes apply at once.
        cnt_d[c]  = '0;
        clk_d[c]  = 1'b0;
        half_d[c] = nxt;
        pv_d[c]   = 1'b0;
      end else if (cnt_q[c] == half_q[c]) begin
        // Half-period boundary: safe point to swap divisor.
        cnt_d[c]  = '0;
        clk_d[c]  = ~clk_q[c];
        tick_d[c] = 1'b1;
        half_d[c] = nxt;
        pv_d[c]   = 1'b0;
        if (hit) pend_d[c] = wr_half;
      end else begin
        cnt_d[c] = cnt_q[c] + 1'b1;
        if (hit) begin
          pend_d[c] = wr_half;
          pv_d[c]   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < N_CH; c++) begin
        cnt_q[c]  <= '0;
        half_q[c] <= RST_HALF;
        pend_q[c] <= '0;
      end
      pv_q   <= '0;
      clk_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        cnt_q[c]  <= cnt_d[c];
        half_q[c] <= half_d[c];
        pend_q[c] <= pend_d[c];
      end
      pv_q   <= pv_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign pending = pv_q;

endmodule
